// File: rtl/pc_run_monitor.sv
// Run controller beside the core: enables it on start, counts cycles and stops on
// halt address, PC self-loop or timeout, reporting status and final cycle count.
module pc_run_monitor #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned STUCK_N   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [ADDR_SIZE-1:0] halt_addr_i,
  input  logic [CNT_W-1:0]     timeout_cycles_i,
  input  logic [ADDR_SIZE-1:0] pc_i,
  output logic                 core_en_o,
  output logic                 running_o,
  output logic                 done_o,
  output logic [1:0]           status_o,
  output logic [CNT_W-1:0]     cycle_count_o
);

  localparam int unsigned        StuckW    = $clog2(STUCK_N) + 1;
  localparam logic [StuckW-1:0]  StuckLast = StuckW'(STUCK_N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   halt_q, halt_d;
  logic [CNT_W-1:0]       tout_q, tout_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             status_q, status_d;
  logic [StuckW-1:0]      stuck_q, stuck_d;
  logic [ADDR_SIZE-1:0]   prev_pc_q, prev_pc_d;
  logic                   prev_vld_q, prev_vld_d;

  logic                   accept_start;
  logic                   same_pc;
  logic [StuckW-1:0]      stuck_inc;
  logic                   halt_ev, loop_ev, tout_ev, run_ev;

  assign accept_start = start_i && (state_q != StRun);
  assign same_pc      = prev_vld_q && (pc_i == prev_pc_q);
  assign stuck_inc    = stuck_q + StuckW'(1);
  assign halt_ev      = (pc_i == halt_q);
  assign loop_ev      = same_pc && (stuck_inc == StuckLast);
  assign tout_ev      = (tout_q != '0) && (cnt_q == tout_q - CNT_W'(1));
  assign run_ev       = halt_ev || loop_ev || tout_ev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (run_ev)  state_d = StDone;
      StDone:  if (start_i) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    core_en_o     = (state_q == StRun);
    running_o     = (state_q == StRun);
    done_o        = (state_q == StDone);
    status_o      = status_q;
    cycle_count_o = cnt_q;
  end

  // Datapath only moves on an accepted start or during RUN; pc is ignored otherwise.
  always_comb begin
    halt_d     = halt_q;
    tout_d     = tout_q;
    cnt_d      = cnt_q;
    status_d   = status_q;
    stuck_d    = stuck_q;
    prev_pc_d  = prev_pc_q;
    prev_vld_d = prev_vld_q;
    if (accept_start) begin
      halt_d     = halt_addr_i;
      tout_d     = timeout_cycles_i;
      cnt_d      = '0;
      status_d   = 2'b00;
      stuck_d    = '0;
      prev_vld_d = 1'b0;
    end else if (state_q == StRun) begin
      cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      stuck_d    = same_pc ? stuck_inc : '0;
      prev_pc_d  = pc_i;
      prev_vld_d = 1'b1;
      if (halt_ev) begin
        status_d = 2'b01;
      end else if (loop_ev) begin
        status_d = 2'b10;
      end else if (tout_ev) begin
        status_d = 2'b11;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      halt_q     <= '0;
      tout_q     <= '0;
      cnt_q      <= '0;
      status_q   <= 2'b00;
      stuck_q    <= '0;
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      halt_q     <= halt_d;
      tout_q     <= tout_d;
      cnt_q      <= cnt_d;
      status_q   <= status_d;
      stuck_q    <= stuck_d;
      prev_pc_q  <= prev_pc_d;
      prev_vld_q <= prev_vld_d;
    end
  end

endmodule

// File: tb/tb_pc_run_monitor.sv
// Bench for pc_run_monitor: directed vector table, hand-written corner sequences and
// randomized runs checked against a history-based reference model.
module tb_pc_run_monitor;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 32;
  localparam int unsigned SN = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] halt_addr;
  logic [CW-1:0] timeout_cycles;
  logic [AW-1:0] pc;
  logic          core_en, running, done;
  logic [1:0]    status;
  logic [CW-1:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_run_monitor #(
    .ADDR_SIZE(AW),
    .CNT_W    (CW),
    .STUCK_N  (SN)
  ) u_dut (
    .clk_i           (clk),
    .rst_ni          (rstn),
    .start_i         (start),
    .halt_addr_i     (halt_addr),
    .timeout_cycles_i(timeout_cycles),
    .pc_i            (pc),
    .core_en_o       (core_en),
    .running_o       (running),
    .done_o          (done),
    .status_o        (status),
    .cycle_count_o   (cycle_count)
  );

  // Reference model: keeps the last SN pc samples of the run and decides events from them.
  bit            m_run, m_done;
  logic [1:0]    m_status;
  logic [CW-1:0] m_count;
  logic [AW-1:0] m_halt;
  logic [CW-1:0] m_tout;
  logic [AW-1:0] m_hist[$];

  function automatic void model_reset();
    m_run = 0; m_done = 0; m_status = 2'b00; m_count = '0;
    m_halt = '0; m_tout = '0; m_hist.delete();
  endfunction

  function automatic void model_edge();
    bit            loop_hit, halt_hit, tout_hit;
    logic [AW-1:0] dropped;
    if (m_run) begin
      m_hist.push_back(pc);
      if (m_hist.size() > SN) dropped = m_hist.pop_front();
      loop_hit = (m_hist.size() == SN);
      foreach (m_hist[i]) if (m_hist[i] != pc) loop_hit = 0;
      halt_hit = (pc == m_halt);
      tout_hit = (m_tout != 0) && (longint'(m_count) + 1 == longint'(m_tout));
      if (m_count != {CW{1'b1}}) m_count = m_count + 1;
      if (halt_hit || loop_hit || tout_hit) begin
        m_status = halt_hit ? 2'd1 : (loop_hit ? 2'd2 : 2'd3);
        m_run = 0;
        m_done = 1;
      end
    end else if (start) begin
      m_run = 1; m_done = 0; m_status = 2'b00; m_count = '0;
      m_halt = halt_addr; m_tout = timeout_cycles; m_hist.delete();
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".running"}, 64'(running), 64'(m_run));
    chk({tag, ".core_en"}, 64'(core_en), 64'(m_run));
    chk({tag, ".done"}, 64'(done), 64'(m_done));
    chk({tag, ".status"}, 64'(status), 64'(m_status));
    chk({tag, ".count"}, 64'(cycle_count), 64'(m_count));
  endtask

  // Inputs are driven 1 time unit after a rising edge and held through the next one.
  task automatic cyc(input logic s, input logic [AW-1:0] p, input string tag);
    start = s;
    pc    = p;
    @(posedge clk);
    model_edge();
    #1;
    start = 1'b0;
    chk_model(tag);
  endtask

  typedef struct {
    logic          start;
    logic [AW-1:0] halt;
    logic [CW-1:0] tout;
    logic [AW-1:0] pc;
    logic          run;
    logic          dn;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t v;
    logic [AW-1:0] p;

    // Scenario 1: halt at 0x1c, pc steps by 4 per cycle.
    tbl.push_back('{1'b1, 32'h1c, 32'd0, 32'h0, 1'b1, 1'b0, 2'd0, 32'd0});
    for (int k = 1; k <= 8; k++)
      tbl.push_back('{1'b0, 32'h1c, 32'd0, 32'((k - 1) * 4), 1'(k < 8), 1'(k == 8),
                      (k == 8) ? 2'd1 : 2'd0, 32'(k)});
    tbl.push_back('{1'b0, 32'h1c, 32'd0, 32'h0, 1'b0, 1'b1, 2'd1, 32'd8});
    // Scenario 2: restart from DONE, pc sticks at 0x10 from cycle 3.
    tbl.push_back('{1'b1, 32'h100, 32'd0, 32'h0, 1'b1, 1'b0, 2'd0, 32'd0});
    tbl.push_back('{1'b0, 32'h100, 32'd0, 32'h08, 1'b1, 1'b0, 2'd0, 32'd1});
    tbl.push_back('{1'b0, 32'h100, 32'd0, 32'h0c, 1'b1, 1'b0, 2'd0, 32'd2});
    for (int k = 3; k <= 6; k++)
      tbl.push_back('{1'b0, 32'h100, 32'd0, 32'h10, 1'(k < 6), 1'(k == 6),
                      (k == 6) ? 2'd2 : 2'd0, 32'(k)});

    rstn = 1'b0; start = 1'b0; halt_addr = '0; timeout_cycles = '0; pc = '0;
    model_reset();
    #12;
    chk("reset.running", 64'(running), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.status", 64'(status), 64'd0);
    chk("reset.count", 64'(cycle_count), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    foreach (tbl[i]) begin
      v = tbl[i];
      halt_addr      = v.halt;
      timeout_cycles = v.tout;
      cyc(v.start, v.pc, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.run", i), 64'(running), 64'(v.run));
      chk($sformatf("vec%0d.done", i), 64'(done), 64'(v.dn));
      chk($sformatf("vec%0d.status", i), 64'(status), 64'(v.st));
      chk($sformatf("vec%0d.count", i), 64'(cycle_count), 64'(v.cnt));
    end

    // Scenario 3a: timeout of 20, halt unreachable.
    halt_addr = 32'hffff_fff0; timeout_cycles = 32'd20;
    cyc(1'b1, 32'h0, "t3a.start");
    for (int k = 1; k <= 20; k++) cyc(1'b0, 32'(k * 4), "t3a");
    chk("t3a.status", 64'(status), 64'd3);
    chk("t3a.count", 64'(cycle_count), 64'd20);

    // Scenario 3b: timeout 0 never expires; inputs changing mid-run are ignored.
    timeout_cycles = 32'd0;
    cyc(1'b1, 32'h0, "t3b.start");
    timeout_cycles = 32'd3;
    halt_addr = 32'h8;
    for (int k = 1; k <= 1100; k++) cyc(1'b0, 32'(k * 4 + 4), "t3b");
    chk("t3b.running", 64'(running), 64'd1);
    chk("t3b.count", 64'(cycle_count), 64'd1100);

    // Scenario 6: asynchronous reset between edges.
    #2 rstn = 1'b0;
    #1;
    chk("rst_async.running", 64'(running), 64'd0);
    chk("rst_async.core_en", 64'(core_en), 64'd0);
    chk("rst_async.done", 64'(done), 64'd0);
    chk("rst_async.status", 64'(status), 64'd0);
    chk("rst_async.count", 64'(cycle_count), 64'd0);
    model_reset();
    @(posedge clk); #3;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk_model("rst_idle");

    // Scenario 4: halt and timeout coincide on cycle 5; halt wins.
    halt_addr = 32'h10; timeout_cycles = 32'd5;
    cyc(1'b1, 32'h0, "t4.start");
    for (int k = 1; k <= 5; k++) cyc(1'b0, 32'((k - 1) * 4), "t4");
    chk("t4.status", 64'(status), 64'd1);
    chk("t4.count", 64'(cycle_count), 64'd5);

    // Scenario 5: start pulse during RUN is ignored.
    halt_addr = 32'h1000; timeout_cycles = 32'd0;
    cyc(1'b1, 32'h0, "t5.start");
    cyc(1'b0, 32'h4, "t5");
    cyc(1'b1, 32'h8, "t5.restart");
    cyc(1'b0, 32'hc, "t5");
    chk("t5.count", 64'(cycle_count), 64'd3);
    chk("t5.running", 64'(running), 64'd1);

    // Randomized runs: small pc alphabet so halts and loops happen often.
    p = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      halt_addr      = 32'($urandom_range(0, 15) * 4);
      timeout_cycles = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      if ($urandom_range(0, 1) == 1) p = 32'($urandom_range(0, 15) * 4);
      cyc(1'($urandom_range(0, 3) == 0), p, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
